// File: rtl/mem_access_unit.sv
// Data memory bus initiator: aligns loads/stores onto a word bus,
// stalls the pipeline until the bus responds, extends load data.
`ifndef MEM_TYPE_LEN
`define MEM_TYPE_LEN 2
`define MEM_TYPE_BYTE 2'b00
`define MEM_TYPE_HALF 2'b01
`define MEM_TYPE_WORD 2'b10
`endif

module mem_access_unit (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [`MEM_TYPE_LEN-1:0] req_type,
  input  logic                     req_signed,
  output logic                     stall,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     addr_error,
  output logic                     bus_valid,
  output logic                     bus_write,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic [3:0]               bus_byteen,
  input  logic                     bus_ready,
  input  logic [31:0]              bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                     bus_valid_q, bus_valid_d;
  logic                     bus_write_q, bus_write_d;
  logic [31:0]              bus_addr_q, bus_addr_d;
  logic [31:0]              bus_wdata_q, bus_wdata_d;
  logic [3:0]               bus_byteen_q, bus_byteen_d;
  logic [1:0]               off_q, off_d;
  logic [`MEM_TYPE_LEN-1:0] type_q, type_d;
  logic                     signed_q, signed_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [31:0]              resp_rdata_q, resp_rdata_d;
  logic                     addr_error_q, addr_error_d;

  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [3:0]  byteen_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode request size, alignment, lane enables and replicated data
  always_comb begin
    is_byte    = (req_type == `MEM_TYPE_BYTE);
    is_half    = (req_type == `MEM_TYPE_HALF);
    misaligned = 1'b0;
    byteen_new = 4'b1111;
    wdata_new  = req_wdata;
    unique case (1'b1)
      is_byte: begin
        byteen_new = 4'b0001 << req_addr[1:0];
        wdata_new  = {4{req_wdata[7:0]}};
      end
      is_half: begin
        misaligned = req_addr[0];
        byteen_new = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{req_wdata[15:0]}};
      end
      default: begin
        misaligned = (req_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Pick the addressed lane from the read word and extend it
  always_comb begin
    byte_sel = 8'h00;
    unique case (off_q)
      2'd0: byte_sel = bus_rdata[7:0];
      2'd1: byte_sel = bus_rdata[15:8];
      2'd2: byte_sel = bus_rdata[23:16];
      2'd3: byte_sel = bus_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_ext = bus_rdata;
    unique case (1'b1)
      (type_q == `MEM_TYPE_BYTE):
        load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      (type_q == `MEM_TYPE_HALF):
        load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default:
        load_ext = bus_rdata;
    endcase
  end

  // Next-state and next-output logic of the access FSM
  always_comb begin
    state_d      = state_q;
    bus_valid_d  = bus_valid_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_byteen_d = bus_byteen_q;
    off_d        = off_q;
    type_d       = type_q;
    signed_d     = signed_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    addr_error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && misaligned) begin
          addr_error_d = 1'b1;
        end else if (req_valid) begin
          state_d      = BUSY;
          bus_valid_d  = 1'b1;
          bus_write_d  = req_write;
          bus_addr_d   = {req_addr[31:2], 2'b00};
          bus_wdata_d  = wdata_new;
          bus_byteen_d = byteen_new;
          off_d        = req_addr[1:0];
          type_d       = req_type;
          signed_d     = req_signed;
        end
      end
      BUSY: begin
        if (bus_ready) begin
          state_d     = DONE;
          bus_valid_d = 1'b0;
          if (!bus_write_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_valid_q  <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      bus_byteen_q <= 4'h0;
      off_q        <= 2'd0;
      type_q       <= '0;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_valid_q  <= bus_valid_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_byteen_q <= bus_byteen_d;
      off_q        <= off_d;
      type_q       <= type_d;
      signed_q     <= signed_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign stall = ((state_q == IDLE) && req_valid && !misaligned)
               || (state_q == BUSY);

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign addr_error = addr_error_q;
  assign bus_valid  = bus_valid_q;
  assign bus_write  = bus_write_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_byteen = bus_byteen_q;

endmodule
